// File: rtl/regfile_multiport_pkg.sv
// rtl/regfile_multiport_pkg.sv - shared widths, types and defaults for the multiport register file
package regfile_multiport_pkg;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_NUM_REGISTER = 32;
    localparam int DEF_NUM_RD_PORTS = 2;
    localparam int DEF_NUM_WR_PORTS = 2;

    localparam int REG_ADDR_WIDTH = $clog2(DEF_NUM_REGISTER);

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DEF_DATA_WIDTH-1:0] word_t;

    // Register x0 is hardwired; any access to it is ignored or reads as zero.
    function automatic logic addr_is_live(input logic [31:0] addr);
        return addr != 32'd0;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy vector with set/clear/flush priority and per-port lookup
module regfile_scoreboard
    import regfile_multiport_pkg::*;
#(
    parameter int NUM_REGISTER = DEF_NUM_REGISTER,
    parameter int NUM_RD_PORTS = DEF_NUM_RD_PORTS,
    parameter int NUM_WR_PORTS = DEF_NUM_WR_PORTS,
    parameter int AW           = $clog2(NUM_REGISTER)
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       flush_i,
    input  logic                       issue_valid_i,
    input  logic [AW-1:0]              issue_rd_addr_i,
    input  logic [NUM_WR_PORTS-1:0]    we_i,
    input  logic [NUM_WR_PORTS*AW-1:0] wr_addr_i,
    input  logic [NUM_RD_PORTS*AW-1:0] rs_addr_i,
    output logic [NUM_RD_PORTS-1:0]    rs_busy_o
);

    logic [NUM_REGISTER-1:0] busy_q;
    logic [NUM_REGISTER-1:0] busy_d;

    // Next busy vector: writeback clears, issue sets (new producer wins), flush clears everything.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NUM_WR_PORTS; w++) begin
            if (we_i[w] && addr_is_live(32'(wr_addr_i[w*AW +: AW]))) begin
                busy_d[wr_addr_i[w*AW +: AW]] = 1'b0;
            end
        end
        if (issue_valid_i && addr_is_live(32'(issue_rd_addr_i))) begin
            busy_d[issue_rd_addr_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    // Busy state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Per-port lookup of the registered busy bit; x0 never reports busy.
    always_comb begin
        rs_busy_o = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            if (addr_is_live(32'(rs_addr_i[p*AW +: AW]))) begin
                rs_busy_o[p] = busy_q[rs_addr_i[p*AW +: AW]];
            end
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - multiport register file with busy scoreboard; REGFILE_BYPASS_EN enables same-cycle forwarding
module regfile_multiport
#(
    parameter int DATA_WIDTH   = regfile_multiport_pkg::DEF_DATA_WIDTH,
    parameter int NUM_REGISTER = regfile_multiport_pkg::DEF_NUM_REGISTER,
    parameter int NUM_RD_PORTS = regfile_multiport_pkg::DEF_NUM_RD_PORTS,
    parameter int NUM_WR_PORTS = regfile_multiport_pkg::DEF_NUM_WR_PORTS,
    localparam int AW          = $clog2(NUM_REGISTER)
) (
    input  logic                               clk_i,
    input  logic                               rst_n_i,
    input  logic                               flush_i,
    input  logic                               issue_valid_i,
    input  logic [AW-1:0]                      issue_rd_addr_i,
    input  logic [NUM_WR_PORTS-1:0]            we_i,
    input  logic [NUM_WR_PORTS*AW-1:0]         wr_addr_i,
    input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0] wr_data_i,
    input  logic [NUM_RD_PORTS*AW-1:0]         rs_addr_i,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rs_data_o,
    output logic [NUM_RD_PORTS-1:0]            rs_busy_o
);

    import regfile_multiport_pkg::*;

    logic [DATA_WIDTH-1:0]   mem_q [NUM_REGISTER];
    logic [NUM_RD_PORTS-1:0] sb_busy;
    logic [NUM_RD_PORTS-1:0] byp_hit;

    regfile_scoreboard #(
        .NUM_REGISTER (NUM_REGISTER),
        .NUM_RD_PORTS (NUM_RD_PORTS),
        .NUM_WR_PORTS (NUM_WR_PORTS),
        .AW           (AW)
    ) u_scoreboard (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .flush_i         (flush_i),
        .issue_valid_i   (issue_valid_i),
        .issue_rd_addr_i (issue_rd_addr_i),
        .we_i            (we_i),
        .wr_addr_i       (wr_addr_i),
        .rs_addr_i       (rs_addr_i),
        .rs_busy_o       (sb_busy)
    );

    // Data array: ports applied in index order so the highest-index port wins a collision; x0 never written.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int r = 0; r < NUM_REGISTER; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WR_PORTS; w++) begin
                if (we_i[w] && addr_is_live(32'(wr_addr_i[w*AW +: AW]))) begin
                    mem_q[wr_addr_i[w*AW +: AW]] <= wr_data_i[w*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Combinational read ports, with optional forwarding of same-cycle writes.
    always_comb begin
        rs_data_o = '0;
        byp_hit   = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            if (addr_is_live(32'(rs_addr_i[p*AW +: AW]))) begin
                rs_data_o[p*DATA_WIDTH +: DATA_WIDTH] = mem_q[rs_addr_i[p*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                for (int w = 0; w < NUM_WR_PORTS; w++) begin
                    if (we_i[w] && (wr_addr_i[w*AW +: AW] == rs_addr_i[p*AW +: AW])) begin
                        rs_data_o[p*DATA_WIDTH +: DATA_WIDTH] = wr_data_i[w*DATA_WIDTH +: DATA_WIDTH];
                        byp_hit[p] = 1'b1;
                    end
                end
`endif
            end
        end
    end

    assign rs_busy_o = sb_busy & ~byp_hit;

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - scoreboard-driven self-checking bench for regfile_multiport
module tb_regfile_multiport;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int NRP = 2;
    localparam int NWP = 2;
    localparam int AW  = 5;

    logic                clk_i = 1'b0;
    logic                rst_n_i;
    logic                flush_i;
    logic                issue_valid_i;
    logic [AW-1:0]       issue_rd_addr_i;
    logic [NWP-1:0]      we_i;
    logic [NWP*AW-1:0]   wr_addr_i;
    logic [NWP*DW-1:0]   wr_data_i;
    logic [NRP*AW-1:0]   rs_addr_i;
    logic [NRP*DW-1:0]   rs_data_o;
    logic [NRP-1:0]      rs_busy_o;

    regfile_multiport #(
        .DATA_WIDTH   (DW),
        .NUM_REGISTER (NR),
        .NUM_RD_PORTS (NRP),
        .NUM_WR_PORTS (NWP)
    ) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .flush_i         (flush_i),
        .issue_valid_i   (issue_valid_i),
        .issue_rd_addr_i (issue_rd_addr_i),
        .we_i            (we_i),
        .wr_addr_i       (wr_addr_i),
        .wr_data_i       (wr_data_i),
        .rs_addr_i       (rs_addr_i),
        .rs_data_o       (rs_data_o),
        .rs_busy_o       (rs_busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0] data;
        logic          busy;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] m_mem [NR];
    logic [NR-1:0] m_busy;
    int            err_cnt = 0;
    int            chk_cnt = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) m_mem[r] = '0;
        m_busy = '0;
    endtask

    // Expected read result for each port given current inputs and model state.
    task automatic push_expect();
        for (int p = 0; p < NRP; p++) begin
            exp_t          e;
            logic [AW-1:0] a;
            a      = rs_addr_i[p*AW +: AW];
            e.data = (a == 0) ? '0 : m_mem[a];
            e.busy = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NWP; w++) begin
                if (rst_n_i && we_i[w] && a != 0 && wr_addr_i[w*AW +: AW] == a) begin
                    e.data = wr_data_i[w*DW +: DW];
                    e.busy = 1'b0;
                end
            end
`endif
            exp_q.push_back(e);
        end
    endtask

    task automatic pop_compare(input string tag);
        for (int p = 0; p < NRP; p++) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                check({tag, "_queue_empty"}, 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("%s_rd%0d_data", tag, p), rs_data_o[p*DW +: DW], e.data);
                check($sformatf("%s_rd%0d_busy", tag, p), 32'(rs_busy_o[p]), 32'(e.busy));
            end
        end
    endtask

    // Reference update at the clock edge, written from the behavioural description.
    task automatic model_edge();
        logic [NR-1:0] nb;
        if (!rst_n_i) return;
        nb = m_busy;
        for (int w = 0; w < NWP; w++) begin
            if (we_i[w] && wr_addr_i[w*AW +: AW] != 0) begin
                m_mem[wr_addr_i[w*AW +: AW]] = wr_data_i[w*DW +: DW];
                nb[wr_addr_i[w*AW +: AW]] = 1'b0;
            end
        end
        if (issue_valid_i && issue_rd_addr_i != 0) nb[issue_rd_addr_i] = 1'b1;
        if (flush_i) nb = '0;
        m_busy = nb;
    endtask

    task automatic step(input string tag);
        push_expect();
        @(negedge clk_i);
        pop_compare(tag);
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic idle();
        we_i          = '0;
        issue_valid_i = 1'b0;
        flush_i       = 1'b0;
    endtask

    task automatic set_rd(input int p, input int a);
        rs_addr_i[p*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int w, input int a, input logic [DW-1:0] d);
        we_i[w]               = 1'b1;
        wr_addr_i[w*AW +: AW] = AW'(a);
        wr_data_i[w*DW +: DW] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst_n_i         = 1'b0;
        idle();
        issue_rd_addr_i = '0;
        wr_addr_i       = '0;
        wr_data_i       = '0;
        rs_addr_i       = '0;

        // Held in reset with activity on the inputs: everything reads as zero.
        for (int i = 0; i < 3; i++) begin
            set_wr(0, 3 + i, 32'hCAFE_0000 + i);
            issue_valid_i   = 1'b1;
            issue_rd_addr_i = AW'(3 + i);
            set_rd(0, 3 + i);
            set_rd(1, 3 + i);
            step("in_reset");
        end
        idle();
        rst_n_i = 1'b1;

        // All registers zero and idle after reset.
        for (int i = 0; i < NR; i++) begin
            set_rd(0, i);
            set_rd(1, NR - 1 - i);
            step("post_reset");
        end

        // Both ports write x5: higher port wins; x0 write ignored.
        set_wr(0, 5, 32'hDEADBEEF);
        set_wr(1, 5, 32'h12345678);
        step("collide_wr");
        idle();
        set_wr(0, 0, 32'hFFFFFFFF);
        set_rd(0, 5);
        set_rd(1, 0);
        step("x5_x0");
        idle();
        @(negedge clk_i);
        check("x5_winner", rs_data_o[0 +: DW], 32'h12345678);
        check("x0_zero", rs_data_o[DW +: DW], 32'h0);
        @(posedge clk_i);
        #1;

        // Issue x7, then writeback clears busy.
        issue_valid_i   = 1'b1;
        issue_rd_addr_i = 5'd7;
        set_rd(0, 7);
        set_rd(1, 7);
        step("issue_x7");
        idle();
        @(negedge clk_i);
        check("x7_busy", 32'(rs_busy_o[0]), 32'd1);
        @(posedge clk_i);
        #1;
        set_wr(1, 7, 32'h000000A5);
        step("wb_x7");
        idle();
        step("after_wb_x7");
        @(negedge clk_i);
        check("x7_data", rs_data_o[0 +: DW], 32'h000000A5);
        check("x7_idle", 32'(rs_busy_o[1]), 32'd0);
        @(posedge clk_i);
        #1;

        // Issue and write x9 together: set wins; flush then clears, data retained.
        issue_valid_i   = 1'b1;
        issue_rd_addr_i = 5'd9;
        set_wr(0, 9, 32'h99990009);
        set_rd(0, 9);
        set_rd(1, 9);
        step("issue_wr_x9");
        idle();
        step("x9_busy");
        flush_i         = 1'b1;
        issue_valid_i   = 1'b1;
        issue_rd_addr_i = 5'd10;
        step("flush");
        idle();
        set_rd(1, 10);
        step("after_flush");
        @(negedge clk_i);
        check("x9_kept", rs_data_o[0 +: DW], 32'h99990009);
        check("x9_clear", 32'(rs_busy_o[0]), 32'd0);
        check("x10_clear", 32'(rs_busy_o[1]), 32'd0);
        @(posedge clk_i);
        #1;

        // Write and read x3 in the same cycle, old value then new.
        set_wr(0, 3, 32'h00000011);
        step("x3_init");
        idle();
        issue_valid_i   = 1'b1;
        issue_rd_addr_i = 5'd3;
        step("x3_issue");
        idle();
        set_wr(1, 3, 32'h00000055);
        set_rd(0, 3);
        set_rd(1, 3);
        step("x3_same_cycle");
        idle();
        step("x3_next");

        // Randomised traffic over a small register window to force collisions.
        for (int i = 0; i < 300; i++) begin
            for (int w = 0; w < NWP; w++) begin
                we_i[w] = 1'($urandom_range(0, 1));
                wr_addr_i[w*AW +: AW] = AW'($urandom_range(0, 7));
                wr_data_i[w*DW +: DW] = $urandom();
            end
            issue_valid_i   = 1'($urandom_range(0, 1));
            issue_rd_addr_i = AW'($urandom_range(0, 7));
            flush_i         = ($urandom_range(0, 15) == 0);
            set_rd(0, $urandom_range(0, 7));
            set_rd(1, $urandom_range(0, 7));
            step("rand");
        end
        idle();

        // Asynchronous reset mid-cycle with a write pending: write lost, outputs zero at once.
        set_wr(0, 4, 32'h0000AAAA);
        step("x4_init");
        set_wr(0, 4, 32'h00001111);
        issue_valid_i   = 1'b1;
        issue_rd_addr_i = 5'd4;
        set_rd(0, 4);
        set_rd(1, 7);
        #2;
        rst_n_i = 1'b0;
        model_reset();
        #1;
        check("mid_rst_rd0", rs_data_o[0 +: DW], 32'h0);
        check("mid_rst_rd1", rs_data_o[DW +: DW], 32'h0);
        check("mid_rst_busy", 32'(rs_busy_o), 32'h0);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        idle();
        step("after_mid_rst");

        if (exp_q.size() != 0) check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
